// File: rtl/riscv_defines.sv
// Shared machine-mode CSR constants: addresses, op codes, bit indices and interrupt causes.
package riscv_defines;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam logic [1:0]  MSTATUS_MPP_M    = 2'b11;

  localparam int unsigned MIP_MSI_BIT = 3;
  localparam int unsigned MIP_MTI_BIT = 7;
  localparam int unsigned MIP_MEI_BIT = 11;

  localparam logic [31:0] IRQ_CAUSE_SW  = 32'h8000_0003;
  localparam logic [31:0] IRQ_CAUSE_TMR = 32'h8000_0007;
  localparam logic [31:0] IRQ_CAUSE_EXT = 32'h8000_000B;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // Unsupported MODE encodings collapse to direct mode.
  function automatic logic [31:0] sanitize_mtvec(input logic [31:0] val, input logic vec_en);
    logic [31:0] r;
    r = {val[31:2], MTVEC_MODE_DIRECT};
    if (vec_en && (val[1:0] == MTVEC_MODE_VECTORED)) r[1:0] = MTVEC_MODE_VECTORED;
    return r;
  endfunction

  // Packed {ext, tmr, sw} interrupt bits <-> architectural mie/mip layout.
  function automatic logic [31:0] irq_to_word(input logic [2:0] b);
    logic [31:0] w;
    w = '0;
    w[MIP_MEI_BIT] = b[2];
    w[MIP_MTI_BIT] = b[1];
    w[MIP_MSI_BIT] = b[0];
    return w;
  endfunction

  function automatic logic [2:0] word_to_irq(input logic [31:0] w);
    return {w[MIP_MEI_BIT], w[MIP_MTI_BIT], w[MIP_MSI_BIT]};
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running CNT_WIDTH counter with independent 32-bit half writes; a write suppresses the increment.
module csr_counter #(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [63:0]          cur, nxt;

  // Work in a 64-bit view so the high-half write and the wrap fall out of truncation.
  always_comb begin
    cur = 64'(cnt_q);
    nxt = cur;
    if (wr_lo) begin
      nxt[31:0] = wdata;
    end else if (wr_hi) begin
      nxt[63:32] = wdata;
    end else if (inc) begin
      nxt = cur + 64'd1;
    end
    cnt_d = nxt[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return, interrupt pending logic and cycle/instret counters.
module csr_trap_unit
  import riscv_defines::*;
#(
  parameter int unsigned CNT_WIDTH   = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  op_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        illegal_o,
  input  logic        retire_i,
  input  logic        trap_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] tval_i,
  input  logic [31:0] pc_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_tmr_i,
  input  logic        irq_sw_i,
  output logic        irq_pending_o,
  output logic [31:0] irq_cause_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] epc_o
);

  localparam logic [31:0] MTVEC_RST_SAN = sanitize_mtvec(MTVEC_RESET, VECTORED_EN);

  csr_op_e op;
  assign op = csr_op_e'(op_i);

  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic [2:0]  mie_q, mie_d;
  logic [2:0]  mip_q;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [CNT_WIDTH-1:0] cycle_cnt, instret_cnt;
  logic [63:0]          cycle64, instret64;

  logic [31:0] mstatus_rd;
  logic [31:0] rdata_raw;
  logic [31:0] rdata_rst;
  logic [31:0] wval;
  logic        addr_impl;
  logic        addr_ro;
  logic        csr_we;
  logic [2:0]  pend;

  assign cycle64   = 64'(cycle_cnt);
  assign instret64 = 64'(instret_cnt);

  always_comb begin
    mstatus_rd                   = '0;
    mstatus_rd[12:11]            = MSTATUS_MPP_M;
    mstatus_rd[MSTATUS_MIE_BIT]  = mst_mie_q;
    mstatus_rd[MSTATUS_MPIE_BIT] = mst_mpie_q;
  end

  always_comb begin
    rdata_raw = '0;
    addr_impl = 1'b1;
    unique case (addr_i)
      CSR_MSTATUS:                  rdata_raw = mstatus_rd;
      CSR_MIE:                      rdata_raw = irq_to_word(mie_q);
      CSR_MTVEC:                    rdata_raw = mtvec_q;
      CSR_MSCRATCH:                 rdata_raw = mscratch_q;
      CSR_MEPC:                     rdata_raw = {mepc_q, 2'b00};
      CSR_MCAUSE:                   rdata_raw = mcause_q;
      CSR_MTVAL:                    rdata_raw = mtval_q;
      CSR_MIP:                      rdata_raw = irq_to_word(mip_q);
      CSR_MCYCLE,    CSR_CYCLE:     rdata_raw = cycle64[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:    rdata_raw = cycle64[63:32];
      CSR_MINSTRET,  CSR_INSTRET:   rdata_raw = instret64[31:0];
      CSR_MINSTRETH, CSR_INSTRETH:  rdata_raw = instret64[63:32];
      default:                      addr_impl = 1'b0;
    endcase
  end

  // While rst is held the read port shows the state the next edge will establish.
  always_comb begin
    rdata_rst = '0;
    if (addr_i == CSR_MSTATUS)    rdata_rst = {19'd0, MSTATUS_MPP_M, 11'd0};
    else if (addr_i == CSR_MTVEC) rdata_rst = MTVEC_RST_SAN;
  end

  assign rdata_o   = rst ? rdata_rst : rdata_raw;
  assign addr_ro   = (addr_i >= CSR_CYCLE) && (addr_i <= CSR_INSTRETH);
  assign illegal_o = (op != CSR_OP_NONE) && (!addr_impl || addr_ro);
  assign csr_we    = (op != CSR_OP_NONE) && !illegal_o && !trap_i && !mret_i;

  always_comb begin
    unique case (op)
      CSR_OP_WRITE: wval = wdata_i;
      CSR_OP_SET:   wval = rdata_raw | wdata_i;
      CSR_OP_CLEAR: wval = rdata_raw & ~wdata_i;
      default:      wval = rdata_raw;
    endcase
  end

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_i) begin
      mepc_d     = pc_i[31:2];
      mcause_d   = cause_i;
      mtval_d    = tval_i;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_i) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (csr_we) begin
      unique case (addr_i)
        CSR_MSTATUS: begin
          mst_mie_d  = wval[MSTATUS_MIE_BIT];
          mst_mpie_d = wval[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = word_to_irq(wval);
        CSR_MTVEC:    mtvec_d    = sanitize_mtvec(wval, VECTORED_EN);
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval[31:2];
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MTVAL:    mtval_d    = wval;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RST_SAN;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mip_q      <= {irq_ext_i, irq_tmr_i, irq_sw_i};
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (1'b1),
    .wr_lo   (csr_we && (addr_i == CSR_MCYCLE)),
    .wr_hi   (csr_we && (addr_i == CSR_MCYCLEH)),
    .wdata   (wval),
    .count_o (cycle_cnt)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc     (retire_i),
    .wr_lo   (csr_we && (addr_i == CSR_MINSTRET)),
    .wr_hi   (csr_we && (addr_i == CSR_MINSTRETH)),
    .wdata   (wval),
    .count_o (instret_cnt)
  );

  assign pend          = mie_q & mip_q;
  assign irq_pending_o = !rst && mst_mie_q && (|pend);

  always_comb begin
    irq_cause_o = '0;
    if (irq_pending_o) begin
      if (pend[2])      irq_cause_o = IRQ_CAUSE_EXT;
      else if (pend[0]) irq_cause_o = IRQ_CAUSE_SW;
      else              irq_cause_o = IRQ_CAUSE_TMR;
    end
  end

  always_comb begin
    trap_pc_o = {mtvec_q[31:2], 2'b00};
    if ((mtvec_q[1:0] == MTVEC_MODE_VECTORED) && cause_i[31])
      trap_pc_o = {mtvec_q[31:2], 2'b00} + {25'd0, cause_i[4:0], 2'b00};
  end

  assign epc_o = rst ? '0 : {mepc_q, 2'b00};

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed vector table plus randomized traffic checked against a behavioural CSR model.
module tb_csr_trap_unit;

  localparam logic [31:0] MTVEC_RST_P = 32'h0000_0203;
  localparam logic [31:0] MTVEC_RST_E = 32'h0000_0200;
  localparam int unsigned N = 0, W = 1, S = 2, C = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  op_i = '0;
  logic [11:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        illegal_o;
  logic        retire_i = 1'b0, trap_i = 1'b0, mret_i = 1'b0;
  logic [31:0] cause_i = '0, tval_i = '0, pc_i = '0;
  logic        irq_ext_i = 1'b0, irq_tmr_i = 1'b0, irq_sw_i = 1'b0;
  logic        irq_pending_o;
  logic [31:0] irq_cause_o, trap_pc_o, epc_o;

  int checks = 0;
  int failures = 0;

  csr_trap_unit #(.CNT_WIDTH(64), .MTVEC_RESET(MTVEC_RST_P), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .illegal_o(illegal_o), .retire_i(retire_i), .trap_i(trap_i),
    .cause_i(cause_i), .tval_i(tval_i), .pc_i(pc_i), .mret_i(mret_i),
    .irq_ext_i(irq_ext_i), .irq_tmr_i(irq_tmr_i), .irq_sw_i(irq_sw_i),
    .irq_pending_o(irq_pending_o), .irq_cause_o(irq_cause_o),
    .trap_pc_o(trap_pc_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [1:0] op; logic [11:0] addr; logic [31:0] wdata;
    logic trap; logic mret; logic retire; logic [2:0] irq; logic [31:0] cause; logic [31:0] pc;
    logic [31:0] e_rdata; logic e_ill; logic e_pend; logic [31:0] e_cause; logic [31:0] e_epc;
    logic chk_tpc; logic [31:0] e_tpc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input int unsigned r, op, addr, wd, tr, mr, rt, irq, cs, pc,
                             erd, eil, epn, ecs, eep, ct, etp);
    vec_t x;
    x.rst = 1'(r); x.op = 2'(op); x.addr = 12'(addr); x.wdata = wd;
    x.trap = 1'(tr); x.mret = 1'(mr); x.retire = 1'(rt); x.irq = 3'(irq);
    x.cause = cs; x.pc = pc; x.e_rdata = erd; x.e_ill = 1'(eil); x.e_pend = 1'(epn);
    x.e_cause = ecs; x.e_epc = eep; x.chk_tpc = 1'(ct); x.e_tpc = etp;
    return x;
  endfunction

  // Behavioural model state
  bit              m_mie, m_mpie;
  logic [31:0]     m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval;
  longint unsigned m_cyc, m_ret;

  function automatic bit is_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, input bit in_rst);
    if (in_rst) return (a == 12'h300) ? 32'h1800 : (a == 12'h305) ? MTVEC_RST_E : 32'h0;
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return m_ie;
      12'h305: return m_tvec;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h343: return m_tval;
      12'h344: return m_ip;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ret[31:0];
      12'hB82, 12'hC82: return m_ret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_illegal();
    return (op_i != 2'd0) && (!is_impl(addr_i) || (addr_i >= 12'hC00 && addr_i <= 12'hC82));
  endfunction

  function automatic bit model_pend();
    return !rst && m_mie && ((m_ie & m_ip) != 32'h0);
  endfunction

  function automatic logic [31:0] model_irq_cause();
    logic [31:0] p;
    p = m_ie & m_ip;
    if (!model_pend()) return 32'h0;
    if (p[11]) return 32'h8000_000B;
    if (p[3])  return 32'h8000_0003;
    return 32'h8000_0007;
  endfunction

  function automatic logic [31:0] model_tpc();
    logic [31:0] base;
    base = m_tvec & 32'hFFFF_FFFC;
    if (m_tvec[1:0] == 2'b01 && cause_i[31]) return base + 32'(cause_i[4:0]) * 4;
    return base;
  endfunction

  task automatic model_step();
    logic [31:0] rd, wv;
    bit we;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_ie = 0; m_ip = 0; m_tvec = MTVEC_RST_E;
      m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_cyc = 0; m_ret = 0;
      return;
    end
    rd = model_read(addr_i, 1'b0);
    wv = (op_i == 2'd1) ? wdata_i : (op_i == 2'd2) ? (rd | wdata_i) : (rd & ~wdata_i);
    we = (op_i != 2'd0) && !model_illegal() && !trap_i && !mret_i;
    if (we && addr_i == 12'hB00)      m_cyc = {m_cyc[63:32], wv};
    else if (we && addr_i == 12'hB80) m_cyc = {wv, m_cyc[31:0]};
    else                              m_cyc = m_cyc + 1;
    if (we && addr_i == 12'hB02)      m_ret = {m_ret[63:32], wv};
    else if (we && addr_i == 12'hB82) m_ret = {wv, m_ret[31:0]};
    else if (retire_i)                m_ret = m_ret + 1;
    m_ip = (32'(irq_ext_i) << 11) | (32'(irq_tmr_i) << 7) | (32'(irq_sw_i) << 3);
    if (trap_i) begin
      m_epc = pc_i & 32'hFFFF_FFFC; m_cause = cause_i; m_tval = tval_i;
      m_mpie = m_mie; m_mie = 0;
    end else if (mret_i) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (we) begin
      case (addr_i)
        12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; end
        12'h304: m_ie = wv & 32'h0000_0888;
        12'h305: m_tvec = (wv & 32'hFFFF_FFFC) | ((wv[1:0] == 2'b01) ? 32'h1 : 32'h0);
        12'h340: m_scratch = wv;
        12'h341: m_epc = wv & 32'hFFFF_FFFC;
        12'h342: m_cause = wv;
        12'h343: m_tval = wv;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    rst = x.rst; op_i = x.op; addr_i = x.addr; wdata_i = x.wdata;
    trap_i = x.trap; mret_i = x.mret; retire_i = x.retire;
    {irq_ext_i, irq_tmr_i, irq_sw_i} = x.irq;
    cause_i = x.cause; pc_i = x.pc; tval_i = 32'h0000_DEAD;
  endtask

  initial begin
    //                r op addr     wdata        tr mr rt irq    cause         pc         rdata         il pn cause         epc           ct tpc
    tbl.push_back(v(1, N, 'h300, 0,            0, 0, 0, 'b000, 0,            0,         'h1800,       0, 0, 0,            0,            0, 0));
    tbl.push_back(v(1, N, 'h305, 0,            0, 0, 0, 'b000, 0,            0,         MTVEC_RST_E,  0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hB00, 0,            0, 0, 0, 'b000, 0,            0,         0,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'h300, 0,            0, 0, 0, 'b000, 0,            0,         'h1800,       0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'h305, 0,            0, 0, 0, 'b000, 0,            0,         MTVEC_RST_E,  0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hB00, 0,            0, 0, 0, 'b000, 0,            0,         3,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hB00, 0,            0, 0, 0, 'b000, 0,            0,         4,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hB00, 0,            0, 0, 0, 'b000, 0,            0,         5,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, W, 'hB00, 'hFFFFFFFF,   0, 0, 0, 'b000, 0,            0,         6,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, W, 'hB80, 0,            0, 0, 0, 'b000, 0,            0,         0,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hB00, 0,            0, 0, 0, 'b000, 0,            0,         'hFFFFFFFF,   0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hB00, 0,            0, 0, 0, 'b000, 0,            0,         0,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hB00, 0,            0, 0, 0, 'b000, 0,            0,         1,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hB80, 0,            0, 0, 0, 'b000, 0,            0,         1,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hC80, 0,            0, 0, 0, 'b000, 0,            0,         1,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, S, 'h300, 8,            0, 0, 0, 'b000, 0,            0,         'h1800,       0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, W, 'h304, 'h880,        0, 0, 0, 'b110, 0,            0,         0,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'h344, 0,            0, 0, 0, 'b110, 0,            0,         'h880,        0, 1, 'h8000000B,   0,            0, 0));
    tbl.push_back(v(0, N, 'h300, 0,            0, 0, 0, 'b010, 0,            0,         'h1808,       0, 1, 'h8000000B,   0,            0, 0));
    tbl.push_back(v(0, N, 'h344, 0,            0, 0, 0, 'b010, 0,            0,         'h080,        0, 1, 'h80000007,   0,            0, 0));
    tbl.push_back(v(0, N, 'h304, 0,            0, 0, 0, 'b000, 0,            0,         'h880,        0, 1, 'h80000007,   0,            0, 0));
    tbl.push_back(v(0, W, 'h305, 'h101,        0, 0, 0, 'b000, 0,            0,         MTVEC_RST_E,  0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, W, 'h340, 'h55,         1, 0, 0, 'b000, 'h80000007,   'h1236,    0,            0, 0, 0,            0,            1, 'h11C));
    tbl.push_back(v(0, N, 'h340, 0,            0, 0, 0, 'b000, 0,            0,         0,            0, 0, 0,            'h1234,       1, 'h100));
    tbl.push_back(v(0, N, 'h300, 0,            0, 0, 0, 'b000, 0,            0,         'h1880,       0, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, N, 'h342, 0,            0, 0, 0, 'b000, 0,            0,         'h80000007,   0, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, N, 'h343, 0,            0, 0, 0, 'b000, 0,            0,         'hDEAD,       0, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, W, 'h300, 0,            0, 1, 0, 'b000, 0,            0,         'h1880,       0, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, N, 'h300, 0,            0, 0, 0, 'b000, 0,            0,         'h1888,       0, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, W, 'hC00, 0,            0, 0, 0, 'b000, 0,            0,         'h12,         1, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, N, 'hC00, 0,            0, 0, 0, 'b000, 0,            0,         'h13,         0, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, S, 'h7C0, 'hFFFF,       0, 0, 0, 'b000, 0,            0,         0,            1, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, W, 'h344, 'hFFF,        0, 0, 0, 'b000, 0,            0,         0,            0, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, N, 'h344, 0,            0, 0, 0, 'b000, 0,            0,         0,            0, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, W, 'h341, 'hFFFFFFFF,   0, 0, 0, 'b000, 0,            0,         'h1234,       0, 0, 0,            'h1234,       0, 0));
    tbl.push_back(v(0, N, 'h341, 0,            0, 0, 0, 'b000, 0,            0,         'hFFFFFFFC,   0, 0, 0,            'hFFFFFFFC,   0, 0));
    tbl.push_back(v(0, W, 'h305, 'h302,        0, 0, 0, 'b000, 0,            0,         'h101,        0, 0, 0,            'hFFFFFFFC,   0, 0));
    tbl.push_back(v(0, N, 'h305, 0,            0, 0, 0, 'b000, 0,            0,         'h300,        0, 0, 0,            'hFFFFFFFC,   0, 0));
    tbl.push_back(v(0, N, 'hB02, 0,            0, 0, 1, 'b000, 'h80000003,   0,         0,            0, 0, 0,            'hFFFFFFFC,   1, 'h300));
    tbl.push_back(v(0, N, 'hC02, 0,            0, 0, 1, 'b000, 0,            0,         1,            0, 0, 0,            'hFFFFFFFC,   0, 0));
    tbl.push_back(v(0, N, 'hB02, 0,            0, 0, 0, 'b000, 0,            0,         2,            0, 0, 0,            'hFFFFFFFC,   0, 0));
    tbl.push_back(v(0, N, 'hB82, 0,            0, 0, 0, 'b100, 0,            0,         0,            0, 0, 0,            'hFFFFFFFC,   0, 0));
    tbl.push_back(v(1, N, 'h300, 0,            1, 0, 1, 'b100, 'h80000007,   'h4444,    'h1800,       0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hB00, 0,            0, 0, 0, 'b000, 0,            0,         0,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'h341, 0,            0, 0, 0, 'b000, 0,            0,         0,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'h305, 0,            0, 0, 0, 'b000, 0,            0,         MTVEC_RST_E,  0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'h300, 0,            0, 0, 0, 'b000, 0,            0,         'h1800,       0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'hB02, 0,            0, 0, 0, 'b000, 0,            0,         0,            0, 0, 0,            0,            0, 0));
    tbl.push_back(v(0, N, 'h342, 0,            0, 0, 0, 'b000, 0,            0,         0,            0, 0, 0,            0,            0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("row%0d rdata", i), rdata_o, tbl[i].e_rdata);
      chk($sformatf("row%0d illegal", i), 32'(illegal_o), 32'(tbl[i].e_ill));
      chk($sformatf("row%0d irq_pending", i), 32'(irq_pending_o), 32'(tbl[i].e_pend));
      chk($sformatf("row%0d irq_cause", i), irq_cause_o, tbl[i].e_cause);
      chk($sformatf("row%0d epc", i), epc_o, tbl[i].e_epc);
      if (tbl[i].chk_tpc) chk($sformatf("row%0d trap_pc", i), trap_pc_o, tbl[i].e_tpc);
      @(posedge clk);
      model_step();
    end

    for (int n = 0; n < 600; n++) begin
      logic [11:0] alist [16];
      alist = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
      @(negedge clk);
      rst      = ($urandom_range(0, 79) == 0);
      op_i     = 2'($urandom_range(0, 3));
      addr_i   = ($urandom_range(0, 7) == 0) ? 12'($urandom) : alist[$urandom_range(0, 15)];
      wdata_i  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      trap_i   = ($urandom_range(0, 11) == 0);
      mret_i   = ($urandom_range(0, 11) == 0);
      retire_i = 1'($urandom);
      {irq_ext_i, irq_tmr_i, irq_sw_i} = 3'($urandom);
      cause_i  = $urandom;
      tval_i   = $urandom;
      pc_i     = $urandom;
      #1;
      chk($sformatf("rnd%0d rdata a=%h", n, addr_i), rdata_o, model_read(addr_i, rst));
      chk($sformatf("rnd%0d illegal", n), 32'(illegal_o), 32'(model_illegal()));
      chk($sformatf("rnd%0d irq_pending", n), 32'(irq_pending_o), 32'(model_pend()));
      chk($sformatf("rnd%0d irq_cause", n), irq_cause_o, model_irq_cause());
      chk($sformatf("rnd%0d trap_pc", n), trap_pc_o, model_tpc());
      chk($sformatf("rnd%0d epc", n), epc_o, rst ? 32'h0 : m_epc);
      @(posedge clk);
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 Parameter CNT_WIDTH, default 64, width of mcycle and minstret counters (32..64); bits above CNT_WIDTH read 0.
REQ-002 Parameter MTVEC_RESET, default 32'h0000_0000, reset value of mtvec.
REQ-003 Parameter VECTORED_EN, default 1, allows mtvec.MODE=1; when 0, MODE is forced to 0.
REQ-004 One clock, reset synchronous active-high; ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-005 Ports: op_i in 2 CSR op (NONE/WRITE/SET/CLEAR); addr_i in 12 CSR address; wdata_i in 32 operand; rdata_o out 32 read data; illegal_o out 1 access fault.
REQ-006 Ports: retire_i in 1 instruction retired; trap_i in 1 take trap; cause_i in 32 mcause value; tval_i in 32 mtval value; pc_i in 32 faulting/interrupted PC; mret_i in 1 return.
REQ-007 Ports: irq_ext_i, irq_tmr_i, irq_sw_i in 1 each, level interrupts; irq_pending_o out 1; irq_cause_o out 32; trap_pc_o out 32 vector target; epc_o out 32 mepc.

Function
REQ-008 Implemented CSRs: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, mcycleh B80, minstret B02, minstreth B82, cycle C00, cycleh C80, instret C02, instreth C82.
REQ-009 rdata_o is combinational from addr_i in the same cycle; unimplemented addresses read 0.
REQ-010 Written value = WRITE: wdata_i; SET: rdata|wdata_i; CLEAR: rdata&~wdata_i; committed at the next clk edge; op NONE never writes.
REQ-011 illegal_o is combinational: 1 when op_i!=NONE and addr_i unimplemented, or addr_i in C00-C82 (read-only); no state changes on an illegal access.
REQ-012 mstatus holds only MIE (bit 3) and MPIE (bit 7); reads MPP=2'b11 (bits 12:11); all other bits read 0.
REQ-013 mie/mip hold only MEIE/MEIP bit 11, MTIE/MTIP bit 7, MSIE/MSIP bit 3; mip is read-only and writes to it are ignored without illegal_o.
REQ-014 mip bits are the irq_*_i inputs registered once: one cycle latency from input to mip.
REQ-015 mtvec: bits 31:2 BASE, bits 1:0 MODE; MODE values other than 0/1 (or 1 with VECTORED_EN=0) are stored as 0; mepc bits 1:0 are always 0.
REQ-016 mcycle increments by 1 every cycle and wraps at 2^CNT_WIDTH to 0; a write to mcycle (or mcycleh) replaces the low (or high) 32 bits, the other half is held, and there is no increment that cycle.
REQ-017 minstret increments when retire_i=1, with the same write and wrap rules as REQ-016.
REQ-018 Trap (trap_i=1) at the next edge: mepc<=pc_i&~3; mcause<=cause_i; mtval<=tval_i; MPIE<=MIE; MIE<=0.
REQ-019 mret_i=1 at the next edge: MIE<=MPIE; MPIE<=1.
REQ-020 Priority: trap_i > mret_i > CSR write; the lower-priority action is discarded in that cycle; counters still count.
REQ-021 irq_pending_o = MIE & |(mie & mip), combinational from registered state.
REQ-022 irq_cause_o = {1'b1, 27'b0, code} with code priority external 11 > software 3 > timer 7; 0 when nothing is pending.
REQ-023 trap_pc_o = BASE<<2 if MODE=0 or cause_i[31]=0; otherwise (BASE<<2) + 4*cause_i[4:0].
REQ-024 epc_o = mepc.

Reset
REQ-025 On rst=1 at an edge: MIE=MPIE=0, mie=0, mip=0, mtvec=MTVEC_RESET (MODE sanitised per REQ-015), mscratch=mepc=mcause=mtval=0, counters=0.
REQ-026 During reset, irq_pending_o=0, irq_cause_o=0, epc_o=0, and rdata_o reflects the reset state; reset overrides trap_i, mret_i and writes.

Structure
REQ-027 CSR addresses, the mstatus/mip bit indices and the interrupt cause codes are constants in the shared riscv_defines package; CSR_OP_* stays there.
REQ-028 One sub-module, csr_counter (parameter CNT_WIDTH; inputs inc, wr_lo, wr_hi, wdata), is instantiated twice for mcycle and minstret.

Verification
REQ-029 Reset, then read 300, 305, B00 -> 32'h1800, MTVEC_RESET, 0; after 5 idle cycles, mcycle reads 5.
REQ-030 Write mcycle=FFFF_FFFF, mcycleh=0 -> after 2 cycles, mcycle=1 and mcycleh=1 (carry into the high half).
REQ-031 Set mstatus MIE and mie=0x880, assert irq_tmr_i and irq_ext_i -> after 1 cycle, irq_pending_o=1 and irq_cause_o=8000_000B.
REQ-032 mtvec=0x101 (vectored); trap_i with cause 8000_0007, pc 0x1236, plus a simultaneous CSR write -> trap_pc_o=0x11C, mepc=0x1234, MIE=0, MPIE=1, and the write is dropped.
REQ-033 mret_i after REQ-032 -> MIE=1, MPIE=1; write to C00 -> illegal_o=1 and the counter is unchanged.
REQ-034 Assert rst mid-trap with counters nonzero -> all state returns to REQ-025 values at the next edge.
